// File: rtl/seg_disp_sched.sv
// Display scheduler: round-robin arbitration of four frame sources, frame latching,
// Start pulse generation for the serial 7-segment driver, periodic refresh and flash clock.
module seg_disp_sched #(
  parameter int unsigned SHIFT_CYCLES   = 160,
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter int unsigned FLASH_DIV      = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] hexs_in,
  input  logic [31:0]  point_in,
  input  logic [31:0]  les_in,
  input  logic [3:0]   mode_in,
  output logic [3:0]   gnt,
  output logic [31:0]  Hexs,
  output logic [7:0]   point,
  output logic [7:0]   LES,
  output logic         SW0,
  output logic         Start,
  output logic         flash,
  output logic         busy,
  output logic [1:0]   last_src
);

  localparam int unsigned ShiftW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int unsigned RefW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned FlashW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [ShiftW-1:0] ShiftLoad = ShiftW'(SHIFT_CYCLES - 1);
  localparam logic [RefW-1:0]   RefLast   = RefW'(REFRESH_CYCLES - 1);
  localparam logic [FlashW-1:0] FlashLast = FlashW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StSend, StWait} state_e;

  state_e              state_q;
  logic [1:0]          ptr_q;
  logic                frame_valid_q;
  logic [RefW-1:0]     ref_cnt_q;
  logic [ShiftW-1:0]   shift_cnt_q;
  logic [FlashW-1:0]   flash_cnt_q;

  logic [7:0] req_dbl;
  logic [7:0] req_rot;
  logic [1:0] offset;
  logic [1:0] winner;
  logic       any_req;

  // Rotate requests so bit k corresponds to source ptr+k; lowest set bit wins.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl >> ptr_q;
    any_req = |req;
    offset  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = 2'(i);
      end
    end
    winner = ptr_q + offset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= 2'd0;
      frame_valid_q <= 1'b0;
      ref_cnt_q     <= '0;
      shift_cnt_q   <= '0;
      gnt           <= 4'd0;
      Hexs          <= 32'd0;
      point         <= 8'd0;
      LES           <= 8'd0;
      SW0           <= 1'b0;
      Start         <= 1'b0;
      busy          <= 1'b0;
      last_src      <= 2'd0;
    end else begin
      gnt   <= 4'd0;
      Start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            // A pending request always wins over a refresh timeout.
            state_q       <= StGrant;
            gnt           <= 4'b0001 << winner;
            Hexs          <= hexs_in[{winner, 5'd0} +: 32];
            point         <= point_in[{winner, 3'd0} +: 8];
            LES           <= les_in[{winner, 3'd0} +: 8];
            SW0           <= mode_in[winner];
            last_src      <= winner;
            ptr_q         <= winner + 2'd1;
            frame_valid_q <= 1'b1;
            busy          <= 1'b1;
            ref_cnt_q     <= '0;
          end else if (frame_valid_q && (ref_cnt_q == RefLast)) begin
            state_q   <= StSend;
            Start     <= 1'b1;
            busy      <= 1'b1;
            ref_cnt_q <= '0;
          end else if (frame_valid_q) begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
          end
        end
        StGrant: begin
          Start   <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          shift_cnt_q <= ShiftLoad;
          state_q     <= StWait;
        end
        StWait: begin
          if (shift_cnt_q == '0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            shift_cnt_q <= shift_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Free-running flash divider, independent of the scheduler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt_q <= '0;
      flash       <= 1'b0;
    end else if (flash_cnt_q == FlashLast) begin
      flash_cnt_q <= '0;
      flash       <= ~flash;
    end else begin
      flash_cnt_q <= flash_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Scoreboard bench for seg_disp_sched: a transaction-level timing model predicts grants,
// Start pulses and frame contents; a negedge monitor compares against the DUT.
module tb_seg_disp_sched;

  localparam int SHIFT   = 8;
  localparam int REFRESH = 20;
  localparam int FDIV    = 3;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] hexs_in;
  logic [31:0]  point_in;
  logic [31:0]  les_in;
  logic [3:0]   mode_in;
  logic [3:0]   gnt;
  logic [31:0]  Hexs;
  logic [7:0]   point;
  logic [7:0]   LES;
  logic         SW0;
  logic         Start;
  logic         flash;
  logic         busy;
  logic [1:0]   last_src;

  seg_disp_sched #(
    .SHIFT_CYCLES  (SHIFT),
    .REFRESH_CYCLES(REFRESH),
    .FLASH_DIV     (FDIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .hexs_in (hexs_in),
    .point_in(point_in),
    .les_in  (les_in),
    .mode_in (mode_in),
    .gnt     (gnt),
    .Hexs    (Hexs),
    .point   (point),
    .LES     (LES),
    .SW0     (SW0),
    .Start   (Start),
    .flash   (flash),
    .busy    (busy),
    .last_src(last_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int edge_no; int src; } gnt_exp_t;
  typedef struct { int edge_no; bit refresh; } start_exp_t;

  gnt_exp_t   gq[$];
  start_exp_t sq[$];
  int         grant_log[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks when the scheduler is next free and the last idle start,
  // and derives every event time from those with plain arithmetic.
  int          edge_n = 0;
  int          m_ptr, m_free_at, m_idle_since, m_fk, m_last, m_w;
  bit          m_valid;
  logic [31:0] m_hex;
  logic [7:0]  m_pt, m_les;
  logic        m_mode;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_fk = 0; m_last = 0;
      m_free_at = edge_n + 1; m_idle_since = edge_n + 1;
      m_hex = 0; m_pt = 0; m_les = 0; m_mode = 0;
    end else begin
      m_fk++;
      if (edge_n >= m_free_at) begin
        if (req != 4'd0) begin
          m_w = -1;
          for (int k = 0; k < 4; k++)
            if (m_w < 0 && req[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
          gq.push_back('{edge_no: edge_n, src: m_w});
          sq.push_back('{edge_no: edge_n + 1, refresh: 1'b0});
          m_hex  = hexs_in[32*m_w +: 32];
          m_pt   = point_in[8*m_w +: 8];
          m_les  = les_in[8*m_w +: 8];
          m_mode = mode_in[m_w];
          m_last = m_w;
          m_ptr  = (m_w + 1) % 4;
          m_valid = 1;
          m_free_at = edge_n + SHIFT + 3;
          m_idle_since = m_free_at;
        end else if (m_valid && (edge_n - m_idle_since == REFRESH - 1)) begin
          sq.push_back('{edge_no: edge_n, refresh: 1'b1});
          m_free_at = edge_n + SHIFT + 2;
          m_idle_since = m_free_at;
        end
      end
    end
  end

  // Monitor
  int start_cnt = 0;
  int refresh_cnt = 0;
  int prev_start = -1;
  int run = 0;
  int last_run = 0;
  bit run_grant = 0;

  always @(negedge clk) begin
    gnt_exp_t   ge;
    start_exp_t se;
    if (rst) begin
      run = 0;
      prev_start = -1;
    end else begin
      if (gnt != 4'd0) begin
        if (gq.size() == 0) check("unexpected_gnt", gnt, 0);
        else begin
          ge = gq.pop_front();
          check("gnt_edge", edge_n, ge.edge_no);
          check("gnt_onehot", gnt, 4'b0001 << ge.src);
          grant_log.push_back(ge.src);
        end
      end
      if (Start) begin
        start_cnt++;
        if (sq.size() == 0) check("unexpected_start", Start, 0);
        else begin
          se = sq.pop_front();
          check("start_edge", edge_n, se.edge_no);
          if (se.refresh) refresh_cnt++;
          if (prev_start >= 0) begin
            check("start_spacing_min", (edge_n - prev_start) >= SHIFT + 2, 1);
            if (se.refresh) check("refresh_period", edge_n - prev_start, REFRESH + SHIFT + 1);
          end
        end
        prev_start = edge_n;
      end
      check("frame_hexs", Hexs, m_hex);
      check("frame_point", point, m_pt);
      check("frame_les", LES, m_les);
      check("frame_sw0", SW0, m_mode);
      check("last_src", last_src, m_last);
      check("busy", busy, (edge_n + 1) < m_free_at);
      check("flash", flash, (m_fk / FDIV) % 2);
      if (busy) begin
        if (run == 0) run_grant = (gnt != 4'd0);
        run++;
      end else if (run > 0) begin
        check("busy_width", run, run_grant ? SHIFT + 2 : SHIFT + 1);
        last_run = run;
        run = 0;
      end
    end
  end

  // Driver helpers: each step lands just after a falling edge; granted sources drop req.
  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (gnt[i]) req[i] = 1'b0;
  endtask

  task automatic raise(input int src, input logic [31:0] h, input logic [7:0] p,
                       input logic [7:0] l, input logic m);
    hexs_in[32*src +: 32] = h;
    point_in[8*src +: 8]  = p;
    les_in[8*src +: 8]    = l;
    mode_in[src]          = m;
    req[src]              = 1'b1;
  endtask

  task automatic raise_rand(input int src);
    raise(src, $urandom, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    while (gnt == 4'd0 && n < 100) begin step(); n++; end
    if (gnt == 4'd0) check({name, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((req != 4'd0 || busy) && n < 500) begin step(); n++; end
    if (req != 4'd0 || busy) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    req = 4'd0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_start", Start, 0);
    check("rst_busy", busy, 0);
    check("rst_hexs", Hexs, 0);
    check("rst_point", point, 0);
    check("rst_les", LES, 0);
    check("rst_sw0", SW0, 0);
    check("rst_last_src", last_src, 0);
    check("rst_flash", flash, 0);
    gq.delete();
    sq.delete();
    grant_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, coll_edge, overdue, n;
    rst = 1'b1; req = 4'd0; hexs_in = '0; point_in = '0; les_in = '0; mode_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_gnt", gnt, 0);
    check("init_start", Start, 0);
    check("init_busy", busy, 0);
    check("init_hexs", Hexs, 0);
    #1 rst = 1'b0;
    step();
    check("flash_after_release", flash, 0);

    // No grant since reset: no Start at all.
    repeat (60) step();
    check("no_start_before_grant", start_cnt, 0);

    // Single request from source 2.
    raise(2, 32'hDEADBEEF, 8'h0F, 8'hA5, 1'b1);
    wait_gnt("single");
    check("single_gnt", gnt, 4'b0100);
    check("single_hexs", Hexs, 32'hDEADBEEF);
    check("single_point", point, 8'h0F);
    check("single_les", LES, 8'hA5);
    check("single_sw0", SW0, 1);
    step();
    check("single_start", Start, 1);
    wait_idle("single");
    check("single_busy_width", last_run, 10);

    // Reset mid-WAIT.
    raise_rand(1);
    wait_gnt("midwait");
    repeat (5) step();
    check("midwait_busy", busy, 1);
    do_reset();

    // Reset while Start is high.
    raise_rand(3);
    wait_gnt("starthigh");
    step();
    check("starthigh_start", Start, 1);
    do_reset();

    // Round-robin from a fresh pointer.
    for (int i = 0; i < 4; i++) raise_rand(i);
    wait_idle("rr4");
    check("rr4_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("rr4_order", grant_log[i], i);
    grant_log.delete();
    raise_rand(0);
    raise_rand(1);
    wait_idle("rr2");
    check("rr2_count", grant_log.size(), 2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++) check("rr2_order", grant_log[i], i);

    // Refresh while idle.
    r0 = refresh_cnt;
    repeat (100) step();
    check("refresh_count_ge3", (refresh_cnt - r0) >= 3, 1);

    // Request rising exactly on the refresh-timeout edge.
    n = 0;
    while (!(edge_n == m_idle_since + REFRESH - 2 && !busy) && n < 200) begin step(); n++; end
    coll_edge = edge_n + 1;
    s0 = start_cnt;
    r0 = refresh_cnt;
    raise_rand(2);
    wait_gnt("collision");
    check("collision_gnt_edge", edge_n, coll_edge);
    check("collision_gnt", gnt, 4'b0100);
    wait_idle("collision");
    check("collision_one_start", start_cnt - s0, 1);
    check("collision_no_refresh", refresh_cnt - r0, 0);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      int mask = $urandom_range(1, 15);
      for (int i = 0; i < 4; i++) if (mask[i] && !req[i]) raise_rand(i);
      repeat ($urandom_range(0, 45)) step();
      if (it == 20) do_reset();
    end
    wait_idle("random");
    repeat (60) step();

    overdue = 0;
    foreach (gq[i]) if (gq[i].edge_no < edge_n) overdue++;
    foreach (sq[i]) if (sq[i].edge_no < edge_n) overdue++;
    check("overdue_events", overdue, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
